reg_bank_reader: RTL

Sequential read-out engine for the processor's register bank, which is built from write-enabled registers. On a start command it walks a contiguous address range through the bank's combinational read port. It streams each word out on a valid/ready interface, so register contents can be dumped to a debug or trace consumer without stalling the datapath's write side.

---
 rtl/reg_bank_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/reg_bank_reader.sv
// reg_bank_reader: walks a contiguous address range of a register bank through
// its combinational read port and streams each word out on valid/ready.
// Optional feature macro: READER_PARITY_EN adds a registered even-parity
// output out_par that tracks out_data.
module reg_bank_reader #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
`ifdef READER_PARITY_EN
  output logic          done,
  output logic          out_par
`else
  output logic          done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] REMAIN_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW:0]   remain_q, remain_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef READER_PARITY_EN
  logic          out_par_q, out_par_d;
`endif

  // Next-state and registered-output computation for the read-out FSM.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        // A zero-length command is dropped without any visible activity.
        if (start && (count != '0)) begin
          cur_addr_d = base_addr;
          remain_d   = count;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        out_last_d  = (remain_q == REMAIN_ONE);
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (remain_q == REMAIN_ONE) begin
            out_last_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            // Address wraps naturally at the AW-bit boundary.
            cur_addr_d = cur_addr_q + 1'b1;
            remain_d   = remain_q - 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // busy and done are registered, so they are derived from the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

`ifdef READER_PARITY_EN
  // Parity is computed from the value being loaded so it stays aligned with out_data.
  always_comb begin
    out_par_d = ^out_data_d;
  end
`endif

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef READER_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef READER_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign rd_addr   = cur_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef READER_PARITY_EN
  assign out_par   = out_par_q;
`endif

endmodule
